// File: rtl/pipe_pkg.sv
// Shared ID/EX types: opcodes, control bundle, operand-use decode.
package pipe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] srca_sel;
    logic [2:0] srcb_sel;
    logic [1:0] rf_sel;
    logic       rf_we;
    logic       mem_we2;
    logic       mem_rden2;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic rs1_used(input logic [6:0] op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic rs2_used(input logic [6:0] op);
    return op inside {OP_OP, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID/EX boundary bundle: decode side in, execute side out.
interface id_ex_pipe_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_fun;
  logic [1:0]      id_srca_sel;
  logic [2:0]      id_srcb_sel;
  logic [1:0]      id_rf_sel;
  logic            id_rf_we;
  logic            id_mem_we2;
  logic            id_mem_rden2;

  logic            ex_valid;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [3:0]      ex_alu_fun;
  logic [1:0]      ex_srca_sel;
  logic [2:0]      ex_srcb_sel;
  logic [1:0]      ex_rf_sel;
  logic            ex_rf_we;
  logic            ex_mem_we2;
  logic            ex_mem_rden2;

  logic            stall_in;
  logic            flush;
  logic            hz_stall;

  modport master (
    output id_valid, id_opcode, id_funct3,
    output id_rd, id_rs1, id_rs2,
    output id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_alu_fun, id_srca_sel, id_srcb_sel,
    output id_rf_sel, id_rf_we, id_mem_we2,
    output id_mem_rden2, stall_in, flush,
    input  ex_valid, ex_opcode, ex_funct3,
    input  ex_rd, ex_rs1, ex_rs2,
    input  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
    input  ex_alu_fun, ex_srca_sel, ex_srcb_sel,
    input  ex_rf_sel, ex_rf_we, ex_mem_we2,
    input  ex_mem_rden2, hz_stall
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3,
    input  id_rd, id_rs1, id_rs2,
    input  id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_alu_fun, id_srca_sel, id_srcb_sel,
    input  id_rf_sel, id_rf_we, id_mem_we2,
    input  id_mem_rden2, stall_in, flush,
    output ex_valid, ex_opcode, ex_funct3,
    output ex_rd, ex_rs1, ex_rs2,
    output ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
    output ex_alu_fun, ex_srca_sel, ex_srcb_sel,
    output ex_rf_sel, ex_rf_we, ex_mem_we2,
    output ex_mem_rden2, hz_stall
  );
endinterface

// File: rtl/load_use_det.sv
// Combinational load-use detector between a load in EX and
// a consumer in ID; x0 never matches.
module load_use_det
  import pipe_pkg::*;
(
  input  logic       rst,
  input  logic       flush,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_rden2,
  input  logic [4:0] ex_rd,
  output logic       hz
);
  logic ld_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  assign ld_in_ex = ex_valid & ex_mem_rden2
                  & (ex_rd != 5'd0);
  assign rs1_hit  = rs1_used(id_opcode)
                  & (id_rs1 == ex_rd);
  assign rs2_hit  = rs2_used(id_opcode)
                  & (id_rs2 == ex_rd);

  // A redirect kills the consumer anyway, so never stall on it.
  assign hz = ~rst & ~flush & id_valid & ld_in_ex
            & (rs1_hit | rs2_hit);
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush, stall and bubble insertion.
// Define ID_EX_LOAD_USE_EN to enable internal load-use detection.
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  id_ex_pipe_if.slave bus
);
  ctrl_t           id_ctrl;
  ctrl_t           ex_ctrl;
  logic            ex_valid;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic            load_use;
  logic            hold;
  logic            kill;

  assign id_ctrl = '{
    alu_fun:   bus.id_alu_fun,
    srca_sel:  bus.id_srca_sel,
    srcb_sel:  bus.id_srcb_sel,
    rf_sel:    bus.id_rf_sel,
    rf_we:     bus.id_rf_we,
    mem_we2:   bus.id_mem_we2,
    mem_rden2: bus.id_mem_rden2
  };

`ifdef ID_EX_LOAD_USE_EN
  load_use_det u_load_use_det (
    .rst          (rst),
    .flush        (bus.flush),
    .id_valid     (bus.id_valid),
    .id_opcode    (bus.id_opcode),
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .ex_valid     (ex_valid),
    .ex_mem_rden2 (ex_ctrl.mem_rden2),
    .ex_rd        (ex_rd),
    .hz           (load_use)
  );
`else
  assign load_use = 1'b0;
`endif

  assign bus.hz_stall = load_use;

  // flush beats stall; stall beats a bubble
  assign hold = bus.stall_in & ~bus.flush;
  assign kill = bus.flush | load_use | ~bus.id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
    end else if (!hold) begin
      ex_valid    <= ~kill;
      ex_ctrl     <= kill ? CTRL_BUBBLE : id_ctrl;
      ex_opcode   <= bus.id_opcode;
      ex_funct3   <= bus.id_funct3;
      ex_rd       <= bus.id_rd;
      ex_rs1      <= bus.id_rs1;
      ex_rs2      <= bus.id_rs2;
      ex_pc       <= bus.id_pc;
      ex_rs1_data <= bus.id_rs1_data;
      ex_rs2_data <= bus.id_rs2_data;
      ex_imm      <= bus.id_imm;
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_opcode    = ex_opcode;
  assign bus.ex_funct3    = ex_funct3;
  assign bus.ex_rd        = ex_rd;
  assign bus.ex_rs1       = ex_rs1;
  assign bus.ex_rs2       = ex_rs2;
  assign bus.ex_pc        = ex_pc;
  assign bus.ex_rs1_data  = ex_rs1_data;
  assign bus.ex_rs2_data  = ex_rs2_data;
  assign bus.ex_imm       = ex_imm;
  assign bus.ex_alu_fun   = ex_ctrl.alu_fun;
  assign bus.ex_srca_sel  = ex_ctrl.srca_sel;
  assign bus.ex_srcb_sel  = ex_ctrl.srcb_sel;
  assign bus.ex_rf_sel    = ex_ctrl.rf_sel;
  assign bus.ex_rf_we     = ex_ctrl.rf_we;
  assign bus.ex_mem_we2   = ex_ctrl.mem_we2;
  assign bus.ex_mem_rden2 = ex_ctrl.mem_rden2;
endmodule
